// File: rtl/mac_host_if.sv
// Host stream, result stream and MAC pin bundle between the host logic and the MAC sequencer.
// The sequencer connects through the slave modport; the host and MAC side connect through master.
interface mac_host_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic [23:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic [7:0]  mac_ui;
  logic        mac_load_en;
  logic [1:0]  mac_read_sel;
  logic        mac_clr_acc;
  logic [7:0]  mac_uo;

  modport slave (
    input  in_valid, in_a, in_b, in_last, res_ready, mac_uo,
    output in_ready, res_data, res_valid, busy,
    output mac_ui, mac_load_en, mac_read_sel, mac_clr_acc
  );

  modport master (
    output in_valid, in_a, in_b, in_last, res_ready, mac_uo,
    input  in_ready, res_data, res_valid, busy,
    input  mac_ui, mac_load_en, mac_read_sel, mac_clr_acc
  );
endinterface

// File: rtl/mac_host_sequencer.sv
// Host-side sequencer for the byte-serial 8x8 signed MAC: loads operand pairs, reads back
// the 24-bit accumulator at batch end and presents it as one result. All outputs registered.
module mac_host_sequencer #(
  parameter int DRAIN_CYCLES  = 1,
  parameter bit CLR_PER_BATCH = 1'b1
) (
  input logic       i_clk,
  input logic       i_rst,
  mac_host_if.slave bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_DRAIN, S_READ, S_RESP
  } state_t;

  state_t      r_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_last;
  logic [1:0]  r_ptr;
  logic [1:0]  r_rd_idx;
  logic [DW-1:0] r_drain;
  logic        r_batch_first;
  logic        r_in_ready;
  logic        r_busy;
  logic        r_res_valid;
  logic [23:0] r_res_data;
  logic [7:0]  r_mac_ui;
  logic        r_mac_load_en;
  logic [1:0]  r_mac_read_sel;
  logic        r_mac_clr_acc;

  assign bus.in_ready     = r_in_ready;
  assign bus.busy         = r_busy;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_data     = r_res_data;
  assign bus.mac_ui       = r_mac_ui;
  assign bus.mac_load_en  = r_mac_load_en;
  assign bus.mac_read_sel = r_mac_read_sel;
  assign bus.mac_clr_acc  = r_mac_clr_acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_a            <= '0;
      r_b            <= '0;
      r_last         <= 1'b0;
      r_ptr          <= '0;
      r_rd_idx       <= '0;
      r_drain        <= '0;
      r_batch_first  <= 1'b1;
      r_in_ready     <= 1'b1;
      r_busy         <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_mac_ui       <= '0;
      r_mac_load_en  <= 1'b0;
      r_mac_read_sel <= '0;
      r_mac_clr_acc  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.in_a;
            r_b        <= bus.in_b;
            r_last     <= bus.in_last;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (r_batch_first && CLR_PER_BATCH) begin
              r_state       <= S_CLEAR;
              r_mac_clr_acc <= 1'b1;
            end else begin
              r_state       <= S_LOAD;
              r_mac_load_en <= 1'b1;
              r_mac_ui      <= bus.in_a;
            end
          end
        end
        S_CLEAR: begin
          r_mac_clr_acc <= 1'b0;
          r_batch_first <= 1'b0;
          r_state       <= S_LOAD;
          r_mac_load_en <= 1'b1;
          r_mac_ui      <= r_a;
        end
        S_LOAD: begin
          // Trailing zero loads return the MAC operands to zero so only a*b accumulates.
          r_ptr <= r_ptr + 2'd1;
          case (r_ptr)
            2'd0: r_mac_ui <= r_b;
            2'd1: r_mac_ui <= 8'h00;
            2'd2: r_mac_ui <= 8'h00;
            default: begin
              r_mac_load_en <= 1'b0;
              r_mac_ui      <= 8'h00;
              if (r_last) begin
                r_state <= S_DRAIN;
                r_drain <= DW'(DRAIN_CYCLES - 1);
              end else begin
                r_state    <= S_IDLE;
                r_in_ready <= 1'b1;
                r_busy     <= 1'b0;
              end
            end
          endcase
        end
        S_DRAIN: begin
          if (r_drain == '0) begin
            r_state        <= S_READ;
            r_rd_idx       <= 2'd0;
            r_mac_read_sel <= 2'd0;
          end else begin
            r_drain <= r_drain - 1'b1;
          end
        end
        S_READ: begin
          case (r_rd_idx)
            2'd0:    r_res_data[7:0]   <= bus.mac_uo;
            2'd1:    r_res_data[15:8]  <= bus.mac_uo;
            default: r_res_data[23:16] <= bus.mac_uo;
          endcase
          if (r_rd_idx == 2'd2) begin
            r_state        <= S_RESP;
            r_res_valid    <= 1'b1;
            r_mac_read_sel <= 2'd0;
          end else begin
            r_rd_idx       <= r_rd_idx + 2'd1;
            r_mac_read_sel <= r_rd_idx + 2'd1;
          end
        end
        S_RESP: begin
          if (bus.res_ready) begin
            r_res_valid   <= 1'b0;
            r_batch_first <= 1'b1;
            r_state       <= S_IDLE;
            r_in_ready    <= 1'b1;
            r_busy        <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_host_sequencer.sv
// Bench for mac_host_sequencer: behavioural MAC on the pins, transaction-level expected
// pin schedule and batch sums, directed cases plus randomized batches.
module tb_mac_host_sequencer;
  localparam int DRAIN = 1;
  localparam bit CLRB  = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_host_if bus();

  mac_host_sequencer #(.DRAIN_CYCLES(DRAIN), .CLR_PER_BATCH(CLRB)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  // MAC pin model: alternating A/B loads, registered product, accumulate every cycle
  logic signed [7:0]  m_a, m_b;
  logic               m_tog;
  logic signed [15:0] m_prod;
  logic [23:0]        m_acc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= '0; m_b <= '0; m_tog <= 1'b0; m_prod <= '0; m_acc <= '0;
    end else begin
      m_prod <= m_a * m_b;
      if (bus.mac_clr_acc) m_acc <= '0;
      else                 m_acc <= m_acc + {{8{m_prod[15]}}, m_prod};
      if (bus.mac_load_en) begin
        if (!m_tog) m_a <= bus.mac_ui;
        else        m_b <= bus.mac_ui;
        m_tog <= ~m_tog;
      end
    end
  end
  assign bus.mac_uo = (bus.mac_read_sel == 2'd0) ? m_acc[7:0] :
                      (bus.mac_read_sel == 2'd1) ? m_acc[15:8] : m_acc[23:16];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference: expected pin activity per cycle, queued on each accepted pair
  typedef struct packed {
    logic [7:0] ui; logic ld; logic [1:0] sel; logic clr; logic fin;
  } ev_t;
  ev_t         q[$];
  ev_t         e;
  logic        m_resp = 1'b0;
  logic        m_bf = 1'b1;
  logic [23:0] m_sum = '0;
  logic [23:0] m_res = '0;
  logic [23:0] got_res = '0;
  int          nres = 0;
  int          load_cnt = 0;
  int          clr_cnt = 0;
  int          prod;
  logic        idle_exp;

  always @(negedge clk) begin
    if (bus.mac_load_en === 1'b1) load_cnt++;
    if (bus.mac_clr_acc === 1'b1) clr_cnt++;
    if (rst) begin
      chk("rst_ctl", {20'd0, bus.mac_ui, bus.mac_load_en, bus.mac_read_sel, bus.mac_clr_acc}, 32'd0);
      chk("rst_hs", {29'd0, bus.in_ready, bus.busy, bus.res_valid}, 32'd4);
      chk("rst_res_data", {8'd0, bus.res_data}, 32'd0);
      q.delete();
      m_resp = 1'b0; m_bf = 1'b1; m_sum = '0;
    end else begin
      e = (q.size() > 0) ? q[0] : '0;
      chk("pins", {20'd0, bus.mac_ui, bus.mac_load_en, bus.mac_read_sel, bus.mac_clr_acc},
          {20'd0, e.ui, e.ld, e.sel, e.clr});
      idle_exp = (q.size() == 0) && !m_resp;
      chk("handshake", {29'd0, bus.in_ready, bus.busy, bus.res_valid},
          {29'd0, idle_exp, !idle_exp, m_resp});
      if (m_resp) chk("res_data", {8'd0, bus.res_data}, {8'd0, m_res});
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.fin) m_resp = 1'b1;
      end else if (m_resp) begin
        if (bus.res_ready) begin
          m_resp = 1'b0; m_bf = 1'b1; got_res = m_res; nres++;
        end
      end else if (bus.in_valid) begin
        if (m_bf && CLRB) begin
          q.push_back('{ui:8'h00, ld:1'b0, sel:2'd0, clr:1'b1, fin:1'b0});
          m_sum = '0;
          m_bf = 1'b0;
        end
        prod = $signed(bus.in_a) * $signed(bus.in_b);
        m_sum = m_sum + prod[23:0];
        q.push_back('{ui:bus.in_a, ld:1'b1, sel:2'd0, clr:1'b0, fin:1'b0});
        q.push_back('{ui:bus.in_b, ld:1'b1, sel:2'd0, clr:1'b0, fin:1'b0});
        q.push_back('{ui:8'h00,    ld:1'b1, sel:2'd0, clr:1'b0, fin:1'b0});
        q.push_back('{ui:8'h00,    ld:1'b1, sel:2'd0, clr:1'b0, fin:1'b0});
        if (bus.in_last) begin
          for (int i = 0; i < DRAIN; i++) q.push_back('0);
          q.push_back('{ui:8'h00, ld:1'b0, sel:2'd0, clr:1'b0, fin:1'b0});
          q.push_back('{ui:8'h00, ld:1'b0, sel:2'd1, clr:1'b0, fin:1'b0});
          q.push_back('{ui:8'h00, ld:1'b0, sel:2'd2, clr:1'b0, fin:1'b1});
          m_res = m_sum;
        end
      end
    end
  end

  // Result consumer
  logic hold_low = 1'b0;
  logic rr_rand = 1'b0;
  initial begin
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (hold_low)     bus.res_ready = 1'b0;
      else if (rr_rand) bus.res_ready = 1'($urandom_range(0, 1));
      else              bus.res_ready = 1'b1;
    end
  end

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
    int k = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_last = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      k++;
      if (k > 3000) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int prev);
    int k = 0;
    while (nres == prev && k < 3000) begin
      @(posedge clk); k++;
    end
    #1;
    if (nres == prev) chk("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int p, c0, l0, k;

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // 1) single pair 3*4
    p = nres; c0 = clr_cnt; l0 = load_cnt;
    send_pair(8'd3, 8'd4, 1'b1);
    wait_result(p);
    chk("t1_res", {8'd0, got_res}, 32'h00000C);
    chk("t1_clr", clr_cnt - c0, 1);
    chk("t1_loads", load_cnt - l0, 4);

    // 2) -128 * -128
    p = nres;
    send_pair(8'h80, 8'h80, 1'b1);
    wait_result(p);
    chk("t2_res", {8'd0, got_res}, 32'h004000);

    // 3) three-pair batch, single clear
    p = nres; c0 = clr_cnt;
    send_pair(8'hFF, 8'd1, 1'b0);
    send_pair(8'd2, 8'd3, 1'b0);
    send_pair(8'h80, 8'd127, 1'b1);
    wait_result(p);
    chk("t3_res", {8'd0, got_res}, 32'hFFC085);
    chk("t3_clr", clr_cnt - c0, 1);

    // 4) 1025 x (-128*-128) wraps modulo 2^24
    p = nres;
    for (int i = 0; i < 1025; i++) send_pair(8'h80, 8'h80, i == 1024);
    wait_result(p);
    chk("t4_res", {8'd0, got_res}, 32'h004000);

    // 5) back-pressure in RESP, in_valid ignored meanwhile
    hold_low = 1'b1;
    p = nres;
    send_pair(8'd7, 8'd9, 1'b1);
    k = 0;
    while (!bus.res_valid && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_a = 8'h55; bus.in_b = 8'h66; bus.in_last = 1'b1;
    l0 = load_cnt;
    repeat (5) begin
      @(negedge clk);
      chk("t5_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("t5_data", {8'd0, bus.res_data}, 32'h00003F);
      chk("t5_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    chk("t5_loads", load_cnt - l0, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    hold_low = 1'b0;
    wait_result(p);
    chk("t5_res", {8'd0, got_res}, 32'h00003F);

    // 6) reset during LOAD1, then a fresh pair
    bus.in_valid = 1'b1; bus.in_a = 8'd9; bus.in_b = 8'd9; bus.in_last = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.in_ready && k < 100);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cycles(2);
    chk("t6_in_load1", {24'd0, bus.mac_ui}, 32'd9);
    rst = 1'b1;
    #1;
    chk("t6_async_rst", {29'd0, bus.in_ready, bus.mac_load_en, bus.busy}, 32'd4);
    cycles(2);
    rst = 1'b0;
    cycles(1);
    p = nres;
    send_pair(8'd5, 8'd5, 1'b1);
    wait_result(p);
    chk("t6_res", {8'd0, got_res}, 32'h000019);

    // Randomized batches with random back-pressure and gaps
    rr_rand = 1'b1;
    for (int bt = 0; bt < 40; bt++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        send_pair(8'($urandom), 8'($urandom), i == n - 1);
        cycles($urandom_range(0, 2));
      end
    end
    p = nres;
    wait_result(p - 1);
    rr_rand = 1'b0;
    k = 0;
    while ((q.size() > 0 || m_resp) && k < 200) begin @(posedge clk); k++; end
    cycles(3);
    chk("final_idle", {31'd0, bus.in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
